// File: rtl/tt_um_halfadder_bist_pkg.sv
// rtl/tt_um_halfadder_bist_pkg.sv - shared types, limits and pin-field positions for the half-adder BIST
// Purpose: FSM state encoding, error-count ceiling, tile pin bit positions and
//          the reference half-adder function used by the checker.
// Ports:   none (package).
package tt_um_halfadder_bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [3:0] ERR_MAX = 4'd15;

  // ui_in fields
  localparam int UI_START   = 0;
  localparam int UI_FAULT   = 2;
  localparam int UI_LOOP_LO = 4;
  localparam int UI_LOOP_HI = 7;

  // uo_out fields
  localparam int UO_BUSY   = 0;
  localparam int UO_DONE   = 1;
  localparam int UO_PASS   = 2;
  localparam int UO_FAIL   = 3;
  localparam int UO_ERR_LO = 4;
  localparam int UO_ERR_HI = 7;

  // uio_out fields
  localparam int UIO_VEC_LO  = 0;
  localparam int UIO_VEC_HI  = 1;
  localparam int UIO_OBS_LO  = 2;
  localparam int UIO_OBS_HI  = 3;
  localparam int UIO_PASS_LO = 4;
  localparam int UIO_PASS_HI = 7;

  // Reference {carry,sum} for operands {b,a}; deliberately independent of the core.
  function automatic logic [1:0] ref_half_add(input logic [1:0] ba);
    return {ba[1] & ba[0], ba[1] ^ ba[0]};
  endfunction

endpackage

// File: rtl/tt_um_halfadder_bist_core.sv
// rtl/tt_um_halfadder_bist_core.sv - combinational half-adder core under test
// Purpose: one-bit half adder.
// Ports:   a, b   in  operand bits
//          sum    out a ^ b
//          carry  out a & b
module half_adder_core (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b;
  assign carry = a & b;

endmodule

// File: rtl/tt_um_halfadder_bist.sv
// rtl/tt_um_halfadder_bist.sv - BIST sequencer and checker around the half-adder core
// Purpose: on a start edge, walks {b,a} through 0..3 for L passes, captures the
//          core output, compares with the reference and reports pass/fail and
//          a saturating error count.
// Ports:   clk, rst_n (async active-low), ena (low freezes all state)
//          ui_in   [0] start, [2] fault inject, [7:4] loop count (0 = 16)
//          uo_out  [0] busy, [1] done, [2] pass, [3] fail, [7:4] error count
//          uio_in  unused
//          uio_out [1:0] vector {b,a}, [3:2] observed {carry,sum}, [7:4] pass index
//          uio_oe  all ones
module tt_um_halfadder_bist
  import tt_um_halfadder_bist_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  logic       s1, s2, s3;
  logic       start_pulse;
  state_t     state;
  logic [1:0] vec;
  logic [1:0] obs_q;
  logic [3:0] pass_idx;
  logic [3:0] err;
  logic [3:0] last_idx;
  logic       core_sum, core_carry;
  logic [1:0] obs_d;
  logic       busy, done;

  assign start_pulse = s2 & ~s3;

  half_adder_core u_core (
    .a     (vec[0]),
    .b     (vec[1]),
    .sum   (core_sum),
    .carry (core_carry)
  );

  // Fault inject sits between the core and the capture register.
  assign obs_d = {core_carry, core_sum ^ ui_in[UI_FAULT]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1       <= 1'b0;
      s2       <= 1'b0;
      s3       <= 1'b0;
      state    <= ST_IDLE;
      vec      <= 2'd0;
      obs_q    <= 2'd0;
      pass_idx <= 4'd0;
      err      <= 4'd0;
      last_idx <= 4'd0;
    end else if (ena) begin
      s1 <= ui_in[UI_START];
      s2 <= s1;
      s3 <= s2;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start_pulse) begin
            vec      <= 2'd0;
            pass_idx <= 4'd0;
            err      <= 4'd0;
            // L-1 in four bits: L=0 wraps to 15, giving 16 passes.
            last_idx <= ui_in[UI_LOOP_HI:UI_LOOP_LO] - 4'd1;
            state    <= ST_DRIVE;
          end
        end
        ST_DRIVE: begin
          obs_q <= obs_d;
          state <= ST_CHECK;
        end
        ST_CHECK: begin
          if ((obs_q != ref_half_add(vec)) && (err != ERR_MAX)) begin
            err <= err + 4'd1;
          end
          if (vec != 2'd3) begin
            vec   <= vec + 2'd1;
            state <= ST_DRIVE;
          end else if (pass_idx == last_idx) begin
            state <= ST_DONE;
          end else begin
            pass_idx <= pass_idx + 4'd1;
            vec      <= 2'd0;
            state    <= ST_DRIVE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy = (state == ST_DRIVE) || (state == ST_CHECK);
  assign done = (state == ST_DONE);

  always_comb begin
    uo_out                       = 8'd0;
    uo_out[UO_BUSY]              = busy;
    uo_out[UO_DONE]              = done;
    uo_out[UO_PASS]              = done & (err == 4'd0);
    uo_out[UO_FAIL]              = done & (err != 4'd0);
    uo_out[UO_ERR_HI:UO_ERR_LO]  = err;
  end

  always_comb begin
    uio_out                          = 8'd0;
    uio_out[UIO_VEC_HI:UIO_VEC_LO]   = vec;
    uio_out[UIO_OBS_HI:UIO_OBS_LO]   = obs_q;
    uio_out[UIO_PASS_HI:UIO_PASS_LO] = pass_idx;
  end

  assign uio_oe = 8'hFF;

  logic unused_ok;
  assign unused_ok = &{1'b0, uio_in, ui_in[3], ui_in[1]};

endmodule

// File: tb/tb_tt_um_halfadder_bist.sv
// tb/tb_tt_um_halfadder_bist.sv - table-driven self-checking bench for tt_um_halfadder_bist
module tb_tt_um_halfadder_bist;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int n_vec = 0;
  int n_miss = 0;

  tt_um_halfadder_bist dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] l;
    logic       fault;
    int         freeze_at;   // active cycle after which ena drops for 5 cycles; 0 = none
    int         exp_cycles;  // cycles from entering DRIVE until done=1
    logic [3:0] exp_err;
    logic       exp_pass;
  } run_t;

  run_t runs[5];

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Expected uio_out while in CHECK (odd active cycle c): vector, captured output, pass index.
  function automatic logic [7:0] exp_uio(input int c, input logic fault);
    int v;
    logic [1:0] o;
    v = ((c - 1) / 2) % 4;
    o = {1'b0, 1'b0};
    o[1] = (v == 3);
    o[0] = ((v == 1) || (v == 2)) ^ fault;
    return {4'((c - 1) / 8), o, 2'(v)};
  endfunction

  // Errors accumulated before the vector being checked at odd active cycle c.
  function automatic int exp_err_at(input int c, input logic fault);
    int e;
    e = fault ? (c - 1) / 2 : 0;
    return (e > 15) ? 15 : e;
  endfunction

  task automatic start_run(input logic [3:0] l, input logic fault);
    ui_in = {l, 1'b0, fault, 1'b0, 1'b0};
    repeat (4) @(negedge clk);
    ui_in[0] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("busy_before_e3", int'(uo_out[0]), 0);
    @(negedge clk);
    chk("busy_after_e3", int'(uo_out[0]), 1);
  endtask

  task automatic run_case(input run_t r);
    int cyc;
    int total;
    int limit;
    start_run(r.l, r.fault);
    cyc = 0;
    total = 0;
    limit = r.exp_cycles + 40;
    while (!uo_out[1] && total < limit) begin
      @(negedge clk);
      cyc++;
      total++;
      if (!uo_out[1] && (cyc % 2 == 1)) begin
        chk("uio_check", int'(uio_out), int'(exp_uio(cyc, r.fault)));
        chk("err_check", int'(uo_out[7:4]), exp_err_at(cyc, r.fault));
        chk("busy_run", int'(uo_out[0]), 1);
      end
      if (r.freeze_at != 0 && cyc == r.freeze_at) begin
        ena = 1'b0;
        repeat (5) begin
          @(negedge clk);
          total++;
          chk("freeze_uio", int'(uio_out), int'(exp_uio(cyc, r.fault)));
          chk("freeze_err", int'(uo_out[7:4]), exp_err_at(cyc, r.fault));
        end
        ena = 1'b1;
      end
    end
    chk("done", int'(uo_out[1]), 1);
    chk("cycles", total, r.exp_cycles);
    chk("busy_end", int'(uo_out[0]), 0);
    chk("pass", int'(uo_out[2]), int'(r.exp_pass));
    chk("fail", int'(uo_out[3]), int'(!r.exp_pass));
    chk("err_final", int'(uo_out[7:4]), int'(r.exp_err));
  endtask

  initial begin
    runs[0] = '{l: 4'd1, fault: 1'b0, freeze_at: 0, exp_cycles: 8,   exp_err: 4'd0,  exp_pass: 1'b1};
    runs[1] = '{l: 4'd1, fault: 1'b1, freeze_at: 0, exp_cycles: 8,   exp_err: 4'd4,  exp_pass: 1'b0};
    runs[2] = '{l: 4'd2, fault: 1'b0, freeze_at: 0, exp_cycles: 16,  exp_err: 4'd0,  exp_pass: 1'b1};
    runs[3] = '{l: 4'd0, fault: 1'b1, freeze_at: 0, exp_cycles: 128, exp_err: 4'd15, exp_pass: 1'b0};
    runs[4] = '{l: 4'd3, fault: 1'b1, freeze_at: 7, exp_cycles: 29,  exp_err: 4'd12, exp_pass: 1'b0};

    rst_n  = 1'b0;
    ena    = 1'b1;
    ui_in  = 8'd0;
    uio_in = 8'd0;
    repeat (3) @(negedge clk);
    chk("reset_uo_out", int'(uo_out), 0);
    chk("reset_uio_out", int'(uio_out), 0);
    chk("reset_uio_oe", int'(uio_oe), 255);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      run_case(runs[i]);
    end

    // Reset in the middle of pass 2 of an L=4 run.
    start_run(4'd4, 1'b0);
    repeat (19) @(negedge clk);
    chk("midrun_pass_idx", int'(uio_out[7:4]), 2);
    #2 rst_n = 1'b0;
    #1;
    chk("midrun_rst_uo_out", int'(uo_out), 0);
    chk("midrun_rst_uio_out", int'(uio_out), 0);
    ui_in = 8'd0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_case('{l: 4'd4, fault: 1'b0, freeze_at: 0, exp_cycles: 32, exp_err: 4'd0, exp_pass: 1'b1});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/tt_um_halfadder_bist.md
# tt_um_halfadder_bist

Built-in self-test front end for the half-adder tile. It is the initiator side of the half-adder pin interface: it sequences all four operand combinations into an embedded half-adder core, checks sum and carry against an independent reference, and reports pass/fail and an error count on the dedicated outputs. It sits at the Tiny Tapeout user-project boundary and uses the standard tile pinout.

## Interface
Parameters:
- none. All widths are fixed by the tile pinout.

Ports:
- clk  in  1  single system clock
- rst_n  in  1  asynchronous, active-low reset
- ena  in  1  tile enable; low freezes all state
- ui_in  in  8  [0] start (level; rising edge triggers), [2] fault inject, [7:4] loop count L (0 means 16), [1],[3] unused
- uo_out  out  8  [0] busy, [1] done, [2] pass, [3] fail, [7:4] error count
- uio_in  in  8  unused
- uio_out  out  8  [1:0] current vector {b,a}, [3:2] last observed {carry,sum}, [7:4] pass index
- uio_oe  out  8  constant 8'hFF

## Operation
- Start path:
  - ui_in[0] passes through a 2-flop synchronizer (s1, s2), then a single edge flop s3.
  - start_pulse = s2 & ~s3.
- FSM states: IDLE, DRIVE, CHECK, DONE.
  - IDLE → DRIVE on start_pulse. At the same time: vec=0, pass_idx=0, err=0, and L is latched (0 latches as 16).
  - DRIVE → CHECK unconditionally. On this edge obs_q captures the core output {carry,sum}.
  - CHECK → DRIVE or DONE:
    - Compare obs_q with the expected value {vec[1]&vec[0], vec[1]^vec[0]}.
    - On mismatch, err increments and saturates at 15.
    - If vec≠3: vec+1, go to DRIVE.
    - Else if pass_idx = L-1: go to DONE.
    - Else: pass_idx+1, vec=0, go to DRIVE.
  - DONE holds until start_pulse. On start_pulse it restarts exactly as from IDLE.
- Core operands: a = vec[0], b = vec[1], taken directly from the vec register.
- Fault inject: when ui_in[2]=1, the core sum output is inverted before capture. The pin is sampled live every DRIVE cycle, without synchronization, and is intended to be static during a run.
- Output decode:
  - busy = (state ∈ {DRIVE, CHECK}).
  - done = (state == DONE).
  - pass = done & (err==0).
  - fail = done & (err≠0).
- ena=0: every register holds its value, including the synchronizer. Outputs keep driving the held values.
- start_pulse during DRIVE/CHECK is ignored.
- Reset values: every output bit is 0 except uio_oe = 8'hFF. All state registers and the synchronizer are 0, and the FSM is in IDLE.

## Timing
- ui_in[0] rises before edge e1. start_pulse is high after e2. The FSM is in DRIVE and busy=1 after e3.
- Each vector takes 2 cycles; each pass takes 8 cycles. A run takes 8·L cycles from entering DRIVE until done=1.
- err and the pass/fail flags update on the edge that leaves CHECK. done, pass and fail are valid in the same cycle.
- Reset mid-run: asynchronous return to IDLE with all outputs cleared. No partial result is retained.
- Wrap-around:
  - vec wraps 3→0 only on a pass boundary.
  - pass_idx counts 0..L-1 (0..15 for L=16) and never wraps within a run.

## Structure
- Shared package: state enum {IDLE, DRIVE, CHECK, DONE}, ERR_MAX=15, field-position constants for the ui_in/uo_out/uio_out bit assignments.
- Sub-module half_adder_core: purely combinational (sum=a^b, carry=a&b), instantiated once.
- The expected-value reference is computed separately in the top level and does not use the core.

## Test plan
- L=1, fault=0, start pulse → busy for 8 cycles; then done=1, pass=1, fail=0, err=0. uio_out[3:2] sequence across vectors: 00, 01, 01, 10.
- L=1, fault=1 → every vector mismatches on sum; done=1, fail=1, err=4.
- L=0 (16 passes), fault=1 → 64 mismatches; err saturates at 15 from the 15th mismatch onward; done after 128 cycles.
- rst_n low in the middle of pass 2 of an L=4 run → uo_out=0 and uio_out=0 immediately; a fresh start then completes normally with pass=1.
- From DONE with err=4, restart with fault=0, L=2 → err clears to 0; done after 16 cycles with pass=1.
- ena=0 for 5 cycles mid-run → state, vec and err are frozen; the run resumes and finishes with the total cycle count extended by exactly 5.
